// File: rtl/teclado_senha.sv
// teclado_senha: 4x4 matrix-keypad front end for the electronic lock.
// It scans the rows one at a time and debounces whole scan passes. Digits
// are collected into a 20-nibble password packet, which the confirm key (#)
// sends to the operational controller.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   teclado_en     keypad enable from the operational controller
//   col_matriz     keypad columns, active low (already synchronised)
//   lin_matriz     keypad row drive, active low
//   digitos_value  last emitted packet, nibble 0 = most recent digit, unused = 4'hF
//   digitos_valid  one-cycle strobe for a new digitos_value
//   bip_tecla      one-cycle pulse per accepted key (buzzer)

package teclado_senha_pkg;
    typedef logic [19:0][3:0] senhaPac_t;
endpackage

module teclado_senha
    import teclado_senha_pkg::*;
#(
    parameter int SCAN_CYCLES     = 1000,
    parameter int DEBOUNCE_PASSES = 4,
    parameter int TIMEOUT_CYCLES  = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       teclado_en,
    input  logic [3:0] col_matriz,
    output logic [3:0] lin_matriz,
    output senhaPac_t  digitos_value,
    output logic       digitos_valid,
    output logic       bip_tecla
);

    localparam int SCW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int DBW = $clog2(DEBOUNCE_PASSES + 1);
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [SCW-1:0] SCAN_LAST  = SCW'(SCAN_CYCLES - 1);
    localparam logic [DBW-1:0] DEB_TARGET = DBW'(DEBOUNCE_PASSES);
    localparam logic [TOW-1:0] IDLE_LAST  = TOW'(TIMEOUT_CYCLES - 1);
    localparam senhaPac_t      EMPTY_PAC  = {20{4'hF}};

    // Internal key codes: 0-9 digits, A-D letters, E = '*', F = '#'.
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    typedef enum logic [1:0] {
        DESLIGADO     = 2'd0,
        ESPERA_TECLA  = 2'd1,
        ESPERA_SOLTAR = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     row_q, row_d;
    logic [SCW-1:0] scan_q, scan_d;
    logic [3:0]     lin_q, lin_d;
    logic [1:0]     hits_q, hits_d;     // keys seen so far in this pass, saturates at 2
    logic [3:0]     code_q, code_d;     // key index when exactly one key seen
    logic [3:0]     last_q, last_d;     // key index being debounced
    logic [DBW-1:0] deb_q, deb_d;
    logic [TOW-1:0] idle_q, idle_d;
    senhaPac_t      buf_q, buf_d;
    senhaPac_t      dv_q, dv_d;
    logic           valid_q, valid_d;
    logic           bip_q, bip_d;

    logic [2:0]     row_cnt_s;
    logic [2:0]     sum_s;
    logic [1:0]     pass_hits_s;
    logic [3:0]     pass_code_s;
    logic           pass_end_s;
    logic           accept_s;
    logic [3:0]     key_s;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    function automatic logic [1:0] col_index(input logic [3:0] v);
        logic [1:0] idx;
        case (1'b1)
            v[0]:    idx = 2'd0;
            v[1]:    idx = 2'd1;
            v[2]:    idx = 2'd2;
            v[3]:    idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] row_drive(input logic [1:0] r);
        logic [3:0] d;
        case (r)
            2'd0:    d = 4'b1110;
            2'd1:    d = 4'b1101;
            2'd2:    d = 4'b1011;
            2'd3:    d = 4'b0111;
            default: d = 4'b1111;
        endcase
        return d;
    endfunction

    // Key index is {row, column}; map it onto the keypad legend.
    function automatic logic [3:0] key_decode(input logic [3:0] idx);
        logic [3:0] k;
        case (idx)
            4'd0:    k = 4'd1;
            4'd1:    k = 4'd2;
            4'd2:    k = 4'd3;
            4'd3:    k = 4'hA;
            4'd4:    k = 4'd4;
            4'd5:    k = 4'd5;
            4'd6:    k = 4'd6;
            4'd7:    k = 4'hB;
            4'd8:    k = 4'd7;
            4'd9:    k = 4'd8;
            4'd10:   k = 4'd9;
            4'd11:   k = 4'hC;
            4'd12:   k = KEY_STAR;
            4'd13:   k = 4'd0;
            4'd14:   k = KEY_HASH;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

    // Merge the current row's columns into the running pass result.
    always_comb begin
        row_cnt_s = popcount4(~col_matriz);
        sum_s     = {1'b0, hits_q} + row_cnt_s;
        if (sum_s >= 3'd2) begin
            pass_hits_s = 2'd2;
        end else begin
            pass_hits_s = sum_s[1:0];
        end
        if (row_cnt_s == 3'd1) begin
            pass_code_s = {row_q, col_index(~col_matriz)};
        end else begin
            pass_code_s = code_q;
        end
    end

    // Scan sequencing, debounce FSM, buffer handling and output strobes.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        scan_d     = scan_q;
        lin_d      = lin_q;
        hits_d     = hits_q;
        code_d     = code_q;
        last_d     = last_q;
        deb_d      = deb_q;
        idle_d     = idle_q;
        buf_d      = buf_q;
        dv_d       = dv_q;
        valid_d    = 1'b0;
        bip_d      = 1'b0;
        pass_end_s = 1'b0;
        accept_s   = 1'b0;
        key_s      = key_decode(pass_code_s);

        if (!teclado_en) begin
            // Disable wins over everything, including a same-cycle acceptance.
            state_d = DESLIGADO;
            row_d   = 2'd0;
            scan_d  = '0;
            lin_d   = 4'hF;
            hits_d  = 2'd0;
            code_d  = 4'd0;
            last_d  = 4'd0;
            deb_d   = '0;
            idle_d  = '0;
            buf_d   = EMPTY_PAC;
        end else if (state_q == DESLIGADO) begin
            state_d = ESPERA_TECLA;
            row_d   = 2'd0;
            scan_d  = '0;
            lin_d   = row_drive(2'd0);
            hits_d  = 2'd0;
            deb_d   = '0;
            idle_d  = '0;
        end else begin
            if (scan_q == SCAN_LAST) begin
                scan_d = '0;
                row_d  = row_q + 2'd1;
                lin_d  = row_drive(row_q + 2'd1);
                if (row_q == 2'd3) begin
                    pass_end_s = 1'b1;
                    hits_d     = 2'd0;
                    code_d     = 4'd0;
                end else begin
                    hits_d = pass_hits_s;
                    code_d = pass_code_s;
                end
            end else begin
                scan_d = scan_q + SCW'(1);
            end

            if (pass_end_s) begin
                case (state_q)
                    ESPERA_TECLA: begin
                        if (pass_hits_s == 2'd1) begin
                            last_d = pass_code_s;
                            if ((deb_q != '0) && (pass_code_s == last_q)) begin
                                deb_d = deb_q + DBW'(1);
                            end else begin
                                deb_d = DBW'(1);
                            end
                            if (deb_d == DEB_TARGET) begin
                                accept_s = 1'b1;
                                deb_d    = '0;
                                state_d  = ESPERA_SOLTAR;
                            end else begin
                                accept_s = 1'b0;
                            end
                        end else begin
                            deb_d = '0;
                        end
                    end
                    ESPERA_SOLTAR: begin
                        if (pass_hits_s == 2'd0) begin
                            deb_d = deb_q + DBW'(1);
                            if (deb_d == DEB_TARGET) begin
                                deb_d   = '0;
                                state_d = ESPERA_TECLA;
                            end else begin
                                state_d = ESPERA_SOLTAR;
                            end
                        end else begin
                            deb_d = '0;
                        end
                    end
                    default: begin
                        state_d = DESLIGADO;
                    end
                endcase
            end else begin
                accept_s = 1'b0;
            end

            // Acceptance takes priority over a coincident timeout.
            if (accept_s) begin
                bip_d  = 1'b1;
                idle_d = '0;
                if (key_s <= 4'd9) begin
                    buf_d = {buf_q[18:0], key_s};
                end else if (key_s == KEY_STAR) begin
                    buf_d = EMPTY_PAC;
                end else if (key_s == KEY_HASH) begin
                    // Nibble 0 is never 4'hF once a digit is stored.
                    if (buf_q[0] != 4'hF) begin
                        dv_d    = buf_q;
                        valid_d = 1'b1;
                        buf_d   = EMPTY_PAC;
                    end else begin
                        valid_d = 1'b0;
                    end
                end else begin
                    buf_d = buf_q;
                end
            end else if (buf_q[0] == 4'hF) begin
                idle_d = '0;
            end else if (idle_q == IDLE_LAST) begin
                idle_d = '0;
                buf_d  = EMPTY_PAC;
            end else begin
                idle_d = idle_q + TOW'(1);
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DESLIGADO;
            row_q   <= 2'd0;
            scan_q  <= '0;
            lin_q   <= 4'hF;
            hits_q  <= 2'd0;
            code_q  <= 4'd0;
            last_q  <= 4'd0;
            deb_q   <= '0;
            idle_q  <= '0;
            buf_q   <= EMPTY_PAC;
            dv_q    <= EMPTY_PAC;
            valid_q <= 1'b0;
            bip_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            scan_q  <= scan_d;
            lin_q   <= lin_d;
            hits_q  <= hits_d;
            code_q  <= code_d;
            last_q  <= last_d;
            deb_q   <= deb_d;
            idle_q  <= idle_d;
            buf_q   <= buf_d;
            dv_q    <= dv_d;
            valid_q <= valid_d;
            bip_q   <= bip_d;
        end
    end

    assign lin_matriz    = lin_q;
    assign digitos_value = dv_q;
    assign digitos_valid = valid_q;
    assign bip_tecla     = bip_q;

endmodule

// File: tb/tb_teclado_senha.sv
// Directed bench for teclado_senha with SCAN_CYCLES=4, DEBOUNCE_PASSES=2,
// TIMEOUT_CYCLES=500 (one scan pass = 16 clocks).
module tb_teclado_senha;
    import teclado_senha_pkg::*;

    localparam int PASS = 16;
    localparam logic [79:0] ALL_F = {20{4'hF}};

    logic       clk = 1'b0;
    logic       rst;
    logic       teclado_en;
    logic [3:0] col_matriz;
    logic [3:0] lin_matriz;
    senhaPac_t  digitos_value;
    logic       digitos_valid;
    logic       bip_tecla;

    logic [15:0] pressed;   // key index = row*4 + column
    logic [3:0]  noise;     // extra column pull-downs independent of rows
    logic [3:0]  kp_cols;

    int n_checks = 0;
    int n_errors = 0;
    int bip_cnt = 0;
    int valid_cnt = 0;
    int bip_base;
    int valid_base;

    teclado_senha #(
        .SCAN_CYCLES(4),
        .DEBOUNCE_PASSES(2),
        .TIMEOUT_CYCLES(500)
    ) dut (
        .clk(clk),
        .rst(rst),
        .teclado_en(teclado_en),
        .col_matriz(col_matriz),
        .lin_matriz(lin_matriz),
        .digitos_value(digitos_value),
        .digitos_valid(digitos_valid),
        .bip_tecla(bip_tecla)
    );

    always #5 clk = ~clk;

    // Passive keypad: a pressed key shorts its column to its driven-low row.
    always_comb begin
        kp_cols = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!lin_matriz[r] && pressed[r*4+c]) kp_cols[c] = 1'b0;
            end
        end
    end
    assign col_matriz = kp_cols & noise;

    always @(negedge clk) begin
        if (bip_tecla) bip_cnt <= bip_cnt + 1;
        if (digitos_valid) valid_cnt <= valid_cnt + 1;
    end

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    function automatic int digit_idx(input int d);
        case (d)
            0: return 13;
            1: return 0;
            2: return 1;
            3: return 2;
            4: return 4;
            5: return 5;
            6: return 6;
            7: return 8;
            8: return 9;
            9: return 10;
            default: return 15;
        endcase
    endfunction

    // Hold a key for 4 passes, then release it for 4 passes.
    task automatic press_key(input int idx);
        pressed = 16'h0000;
        pressed[idx] = 1'b1;
        wait_clks(4 * PASS);
        pressed = 16'h0000;
        wait_clks(4 * PASS);
    endtask

    // Return at the first negedge of a new pass (row 0 just driven).
    task automatic sync_pass();
        int n = 0;
        while (lin_matriz != 4'b0111 && n < 100) begin @(negedge clk); n++; end
        while (lin_matriz != 4'b1110 && n < 100) begin @(negedge clk); n++; end
        check("sync_pass", 80'(n < 100), 80'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        teclado_en = 1'b0;
        pressed = 16'h0000;
        noise = 4'hF;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(1);

        // 1. reset state, columns toggling while disabled
        check("rst_lin", 80'(lin_matriz), 80'(4'hF));
        check("rst_value", digitos_value, ALL_F);
        check("rst_valid", 80'(digitos_valid), 80'(0));
        check("rst_bip", 80'(bip_tecla), 80'(0));
        for (int i = 0; i < 20; i++) begin
            noise = 4'($urandom_range(0, 15));
            wait_clks(1);
        end
        noise = 4'hF;
        check("dis_lin", 80'(lin_matriz), 80'(4'hF));
        check("dis_strobes", 80'(bip_cnt + valid_cnt), 80'(0));

        // 2. enable, row sequence, enter 1 2 3 4 #
        teclado_en = 1'b1;
        @(negedge clk);
        check("row0_first", 80'(lin_matriz), 80'(4'b1110));
        repeat (4) @(negedge clk);
        check("row1_next", 80'(lin_matriz), 80'(4'b1101));
        #1;
        press_key(digit_idx(1));
        press_key(digit_idx(2));
        press_key(digit_idx(3));
        press_key(digit_idx(4));
        press_key(14);
        check("t2_bips", 80'(bip_cnt), 80'(5));
        check("t2_valids", 80'(valid_cnt), 80'(1));
        check("t2_value", digitos_value, {64'hFFFF_FFFF_FFFF_FFFF, 16'h1234});

        // 3. key 5: one pass, one pass released, then steady
        bip_base = bip_cnt;
        sync_pass();
        pressed = 16'h0000;
        pressed[5] = 1'b1;
        repeat (PASS) @(negedge clk);
        pressed = 16'h0000;
        repeat (PASS) @(negedge clk);
        pressed[5] = 1'b1;
        repeat (2 * PASS - 1) @(negedge clk);
        check("t3_no_early", 80'(bip_tecla), 80'(0));
        check("t3_no_early_cnt", 80'(bip_cnt - bip_base), 80'(0));
        @(negedge clk);
        check("t3_accept_time", 80'(bip_tecla), 80'(1));
        wait_clks(50 * PASS);
        check("t3_no_repeat", 80'(bip_cnt - bip_base), 80'(1));
        pressed = 16'h0000;
        wait_clks(4 * PASS);

        // 4. 7+8 together (MULTI), then 7 alone; then 9 * #
        bip_base = bip_cnt;
        valid_base = valid_cnt;
        pressed = 16'h0000;
        pressed[8] = 1'b1;
        pressed[9] = 1'b1;
        wait_clks(5 * PASS);
        check("t4_multi_nobip", 80'(bip_cnt - bip_base), 80'(0));
        pressed[9] = 1'b0;
        wait_clks(4 * PASS);
        pressed = 16'h0000;
        wait_clks(4 * PASS);
        check("t4_seven_once", 80'(bip_cnt - bip_base), 80'(1));
        press_key(digit_idx(9));
        press_key(12);
        press_key(14);
        check("t4_bips", 80'(bip_cnt - bip_base), 80'(4));
        check("t4_no_emit", 80'(valid_cnt - valid_base), 80'(0));
        check("t4_value_kept", digitos_value, {64'hFFFF_FFFF_FFFF_FFFF, 16'h1234});

        // 5. 22 digits then #: last 20 kept
        valid_base = valid_cnt;
        for (int i = 0; i < 22; i++) press_key(digit_idx(i % 10));
        press_key(14);
        check("t5_emit", 80'(valid_cnt - valid_base), 80'(1));
        check("t5_value", digitos_value, 80'h2345_6789_0123_4567_8901);

        // 6a. two digits, idle timeout, # emits nothing
        bip_base = bip_cnt;
        valid_base = valid_cnt;
        press_key(digit_idx(3));
        press_key(digit_idx(8));
        wait_clks(500);
        press_key(14);
        check("t6_timeout_noemit", 80'(valid_cnt - valid_base), 80'(0));
        check("t6_timeout_bips", 80'(bip_cnt - bip_base), 80'(3));

        // 6b. digit, one-clock disable, # emits nothing
        press_key(digit_idx(6));
        teclado_en = 1'b0;
        @(negedge clk);
        check("t6_dis_lin", 80'(lin_matriz), 80'(4'hF));
        #1;
        teclado_en = 1'b1;
        wait_clks(2);
        press_key(14);
        check("t6_dis_noemit", 80'(valid_cnt - valid_base), 80'(0));
        check("t6_dis_value", digitos_value, 80'h2345_6789_0123_4567_8901);

        // 6c. reset during release wait
        pressed = 16'h0000;
        pressed[6] = 1'b1;
        wait_clks(4 * PASS);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_lin", 80'(lin_matriz), 80'(4'hF));
        check("t6_rst_value", digitos_value, ALL_F);
        check("t6_rst_valid", 80'(digitos_valid), 80'(0));
        check("t6_rst_bip", 80'(bip_tecla), 80'(0));
        #1;
        pressed = 16'h0000;
        wait_clks(4);
        rst = 1'b0;
        wait_clks(2);
        check("t6_after_rst_row0", 80'(lin_matriz), 80'(4'b1110));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/teclado_senha.md
# teclado_senha

Matrix-keypad front end for the electronic lock. It scans a 4x4 active-low keypad, debounces key presses and accumulates digits into a password packet. On the confirm key it hands the packet to the operational controller as a one-cycle `digitos_value`/`digitos_valid` pair. It runs only while the controller holds `teclado_en` high.

## Interface
- `SCAN_CYCLES`, 1000: clocks each row is driven before its columns are sampled.
- `DEBOUNCE_PASSES`, 4: consecutive identical full scan passes needed to accept a press or a release.
- `TIMEOUT_CYCLES`, 50_000_000: idle clocks after which a partial entry is discarded.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `teclado_en`  in  1  keypad enable from the operational controller.
- `col_matriz`  in  4  keypad columns, active low, externally pulled up, already synchronised.
- `lin_matriz`  out  4  keypad row drive, active low.
- `digitos_value`  out  senhaPac_t  password packet: 20 BCD nibbles. Index 0 is the most recent digit. Unused nibbles are 4'hF.
- `digitos_valid`  out  1  one-cycle strobe marking a new `digitos_value`.
- `bip_tecla`  out  1  one-cycle pulse for every accepted key, for the buzzer.

## Operation
- **Key map, rows 0–3 × columns 0–3:**
  - Row 0: 1 2 3 A
  - Row 1: 4 5 6 B
  - Row 2: 7 8 9 C
  - Row 3: * 0 # D
- **Scanning.** Rows are driven low one at a time, in order 0,1,2,3, each for `SCAN_CYCLES` clocks. Columns are sampled on the last clock of each row slot. One pass is 4·`SCAN_CYCLES` clocks.
- **Pass result.** Each pass produces exactly one of:
  - `NONE`: no key seen.
  - `KEY(code)`: exactly one key seen.
  - `MULTI`: more than one key seen.
- **States.**
  - `DESLIGADO`: `lin_matriz`=4'hF, buffer cleared, all counters zero.
    - `teclado_en`=1 → `ESPERA_TECLA`.
  - `ESPERA_TECLA`:
    - Counts consecutive passes returning the same `KEY(code)`.
    - `NONE`, `MULTI`, or a different code restarts the count (a different code restarts it at 1).
    - Count reaching `DEBOUNCE_PASSES` → key accepted, `bip_tecla` pulses, → `ESPERA_SOLTAR`.
  - `ESPERA_SOLTAR`:
    - Counts consecutive `NONE` passes; `KEY` or `MULTI` restarts the count.
    - Count reaching `DEBOUNCE_PASSES` → `ESPERA_TECLA`.
    - Exactly one accepted event per physical press.
- **Accepted-key actions.**
  - Digit 0–9: buffer ← {buffer[18:0], digit}. With 20 digits already stored, the oldest digit is dropped.
  - `*`: buffer ← all 4'hF.
  - `#` with a non-empty buffer: `digitos_value` ← buffer, `digitos_valid` pulses, buffer ← all 4'hF.
  - `#` with an empty buffer: `bip_tecla` only, nothing emitted.
  - A–D: `bip_tecla` only, buffer unchanged.
- **Timeout.** The idle counter runs only while the buffer is non-empty and is cleared on every accepted key. When it reaches `TIMEOUT_CYCLES`, the buffer is cleared silently and nothing is emitted.
- **Disable.** `teclado_en`=0 in any state → `DESLIGADO` on the next clock. The partial buffer is lost and no strobe is issued. `digitos_value` keeps its last packet.

## Timing
- **Reset values:**
  - `lin_matriz`=4'hF
  - `digitos_value`=all 4'hF
  - `digitos_valid`=0
  - `bip_tecla`=0
  - state `DESLIGADO`, all counters and buffer cleared
- **Restarting from `DESLIGADO`:** first row-0 drive on the clock after `teclado_en` is seen high. The scan always restarts at row 0.
- **Acceptance instant:** the clock that closes the `DEBOUNCE_PASSES`-th matching pass.
  - `bip_tecla` and (for `#`) `digitos_valid` are registered and high exactly on the following clock.
  - `digitos_value` updates on that same clock and holds until the next `#` emission.
- **Minimum press-to-accept latency:** `DEBOUNCE_PASSES`·4·`SCAN_CYCLES` clocks after the first sampled pass containing the key.
- **`rst` mid-scan:** all outputs return to reset values on the next clock, regardless of `teclado_en`.
- **Simultaneous acceptance and timeout:** acceptance wins. The timeout clear is skipped and the key is applied to the existing buffer.
- **Simultaneous `teclado_en` fall and acceptance:** disable wins. No `bip_tecla` and no `digitos_valid`.

## Test plan
Bench parameters: `SCAN_CYCLES`=4, `DEBOUNCE_PASSES`=2, `TIMEOUT_CYCLES`=500.

1. Reset with `teclado_en`=0 → `lin_matriz`=4'hF, `digitos_value` all F, no strobes while `col_matriz` toggles.
2. Enable, then press and release 1,2,3,4,# with clean contacts → exactly five `bip_tecla` pulses and one `digitos_valid`. `digitos_value` nibbles [3:0]=4,3,2,1; the rest are F.
3. Key 5 bounces for one pass, then is held steady for 2 passes → one acceptance, exactly 1 clock after the second steady pass. Holding it for 50 passes produces no repeat.
4. Press 7 and 8 together for 5 passes (`MULTI`), then 7 alone → only 7 is accepted. Then 9,* → buffer cleared, and a following # emits nothing.
5. Enter 22 digits 0..9,0..9,0,1, then # → packet holds the last 20 digits, index 0 = 1, index 19 = 2.
6. Two digits then 500 idle clocks → # emits nothing. Then 6, `teclado_en` dropped for 1 clock, re-enabled, # → nothing emitted. Then 6 with `rst` asserted during the release wait → all outputs reset.
